// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-line synchroniser and glitch filter,
// x4 decode, wrapping position counter with step/dir/sticky error flags.
module quad_decoder #(
    parameter int COUNT_W     = 16,
    parameter int FILTER_LEN  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enc_a,
    input  logic               enc_b,
    input  logic               clear,
    input  logic               err_clear,
    output logic [COUNT_W-1:0] count,
    output logic               step,
    output logic               dir,
    output logic               error
);

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int ICNT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [ICNT_W-1:0] INIT_LAST = ICNT_W'(SYNC_STAGES);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Returns {next filtered level, next disagreement count} for one line.
    function automatic logic [FCNT_W:0] filter_next(input logic sync_x,
                                                    input logic filt_x,
                                                    input logic [FCNT_W-1:0] cnt);
        logic [FCNT_W:0] res;
        if (sync_x == filt_x) begin
            res = {filt_x, {FCNT_W{1'b0}}};
        end else if (cnt == FILT_LAST) begin
            res = {sync_x, {FCNT_W{1'b0}}};
        end else begin
            res = {filt_x, cnt + FCNT_W'(1)};
        end
        return res;
    endfunction

    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic [1:0]             sync_x_s;
    logic [1:0]             filt_q, filt_d;
    logic [FCNT_W-1:0]      fcnt_a_q, fcnt_a_d;
    logic [FCNT_W-1:0]      fcnt_b_q, fcnt_b_d;
    logic [FCNT_W:0]        fa_s, fb_s;
    logic [1:0]             prev_q, prev_d;
    state_t                 state_q, state_d;
    logic [ICNT_W-1:0]      icnt_q, icnt_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   step_q, step_d;
    logic                   dir_q, dir_d;
    logic                   error_q, error_d;
    logic                   up_s, down_s, illegal_s, run_s;

    // Synchroniser shift chains; the last stage is the usable sample.
    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], enc_a};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], enc_b};
        sync_x_s = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    end

    assign fa_s  = filter_next(sync_x_s[1], filt_q[1], fcnt_a_q);
    assign fb_s  = filter_next(sync_x_s[0], filt_q[0], fcnt_b_q);
    assign run_s = (state_q == ST_RUN);

    // Classify the {prev, cur} filtered pair as up, down or illegal.
    always_comb begin
        up_s      = 1'b0;
        down_s    = 1'b0;
        illegal_s = 1'b0;
        case ({prev_q, filt_q})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: up_s      = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: down_s    = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: illegal_s = 1'b1;
            default: begin
                up_s      = 1'b0;
                down_s    = 1'b0;
                illegal_s = 1'b0;
            end
        endcase
    end

    // FSM next state: INIT bypasses the filter so the lines settle without a false step.
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        filt_d   = filt_q;
        fcnt_a_d = fcnt_a_q;
        fcnt_b_d = fcnt_b_q;
        prev_d   = prev_q;
        case (state_q)
            ST_INIT: begin
                filt_d   = sync_x_s;
                prev_d   = sync_x_s;
                fcnt_a_d = '0;
                fcnt_b_d = '0;
                if (icnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                    icnt_d  = '0;
                end else begin
                    icnt_d = icnt_q + ICNT_W'(1);
                end
            end
            ST_RUN: begin
                filt_d   = {fa_s[FCNT_W], fb_s[FCNT_W]};
                fcnt_a_d = fa_s[FCNT_W-1:0];
                fcnt_b_d = fb_s[FCNT_W-1:0];
                prev_d   = filt_q;
            end
            default: begin
                state_d = ST_INIT;
                icnt_d  = '0;
            end
        endcase
    end

    // Counter, step, direction and sticky error; clear beats a step, a new error beats err_clear.
    always_comb begin
        step_d = run_s & (up_s | down_s);
        if (clear) begin
            count_d = '0;
        end else if (run_s && up_s) begin
            count_d = count_q + COUNT_W'(1);
        end else if (run_s && down_s) begin
            count_d = count_q - COUNT_W'(1);
        end else begin
            count_d = count_q;
        end
        if (run_s && up_s) begin
            dir_d = 1'b1;
        end else if (run_s && down_s) begin
            dir_d = 1'b0;
        end else begin
            dir_d = dir_q;
        end
        if (run_s && illegal_s) begin
            error_d = 1'b1;
        end else if (err_clear) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            filt_q   <= 2'b00;
            fcnt_a_q <= '0;
            fcnt_b_q <= '0;
            prev_q   <= 2'b00;
            state_q  <= ST_INIT;
            icnt_q   <= '0;
            count_q  <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            filt_q   <= filt_d;
            fcnt_a_q <= fcnt_a_d;
            fcnt_b_q <= fcnt_b_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            count_q  <= count_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            error_q  <= error_d;
        end
    end

    assign count = count_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign error = error_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_quad_decoder;

    localparam int COUNT_W     = 16;
    localparam int FILTER_LEN  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MOD         = 1 << COUNT_W;

    logic clk = 1'b0;
    logic reset, enc_a, enc_b, clear, err_clear;
    logic [COUNT_W-1:0] count;
    logic step, dir, error;

    int n_checks  = 0;
    int n_errors  = 0;
    int step_seen = 0;
    int s0, lat, rpos, hold_n;

    always #5 clk = ~clk;

    quad_decoder #(
        .COUNT_W    (COUNT_W),
        .FILTER_LEN (FILTER_LEN),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .clear    (clear),
        .err_clear(err_clear),
        .count    (count),
        .step     (step),
        .dir      (dir),
        .error    (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins delayed by the synchroniser depth, a filter that needs
    // FILTER_LEN consecutive disagreeing samples, and Gray-position arithmetic for decode.
    bit m_valid = 1'b0;
    bit m_run;
    int m_init_n;
    bit m_hist_a[$];
    bit m_hist_b[$];
    bit m_fa, m_fb, m_pa, m_pb;
    int m_ra, m_rb;
    int m_count;
    bit m_step, m_dir, m_err;

    function automatic int gray_pos(bit a, bit b);
        return a ? (b ? 2 : 1) : (b ? 3 : 0);
    endfunction

    task automatic model_step();
        bit sa, sb, err_set;
        int d;
        err_set = 1'b0;
        if (!reset) begin
            m_valid  = 1'b1;
            m_run    = 1'b0;
            m_init_n = 0;
            m_hist_a = {};
            m_hist_b = {};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                m_hist_a.push_back(1'b0);
                m_hist_b.push_back(1'b0);
            end
            m_fa = 0; m_fb = 0; m_pa = 0; m_pb = 0; m_ra = 0; m_rb = 0;
            m_count = 0; m_step = 0; m_dir = 0; m_err = 0;
        end else if (m_valid) begin
            sa = m_hist_a.pop_front();
            sb = m_hist_b.pop_front();
            m_hist_a.push_back(enc_a);
            m_hist_b.push_back(enc_b);
            if (!m_run) begin
                m_fa = sa; m_fb = sb; m_pa = sa; m_pb = sb;
                m_ra = 0; m_rb = 0;
                m_step = 0;
                m_init_n++;
                if (m_init_n == SYNC_STAGES + 1) m_run = 1'b1;
            end else begin
                d = (gray_pos(m_fa, m_fb) - gray_pos(m_pa, m_pb) + 4) % 4;
                m_step = (d == 1) || (d == 3);
                if (d == 1) begin
                    m_count = (m_count + 1) % MOD;
                    m_dir = 1'b1;
                end else if (d == 3) begin
                    m_count = (m_count + MOD - 1) % MOD;
                    m_dir = 1'b0;
                end
                err_set = (d == 2);
                m_pa = m_fa;
                m_pb = m_fb;
                if (sa != m_fa) begin
                    m_ra++;
                    if (m_ra == FILTER_LEN) begin m_fa = sa; m_ra = 0; end
                end else m_ra = 0;
                if (sb != m_fb) begin
                    m_rb++;
                    if (m_rb == FILTER_LEN) begin m_fb = sb; m_rb = 0; end
                end else m_rb = 0;
            end
            if (clear) m_count = 0;
            if (err_set) m_err = 1'b1;
            else if (err_clear) m_err = 1'b0;
        end
    endtask

    // Model advance on each edge, then compare once the registered outputs have settled.
    always @(posedge clk) begin
        model_step();
        #1;
        if (m_valid) begin
            check("count", count, m_count);
            check("step", step, m_step);
            check("dir", dir, m_dir);
            check("error", error, m_err);
            if (step === 1'b1) step_seen++;
        end
    end

    task automatic hold(input logic a, input logic b, input int n);
        enc_a = a;
        enc_b = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; enc_a = 1'b1; enc_b = 1'b1; clear = 1'b0; err_clear = 1'b0;
        repeat (3) @(negedge clk);

        // Release reset with both lines high: INIT must absorb them silently.
        s0 = step_seen;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("init_count", count, 32'd0);
        check("init_error", error, 32'd0);
        check("init_steps", step_seen - s0, 32'd0);

        // Up count from 00 with latency measurement on the first edge.
        enc_a = 1'b0; enc_b = 1'b0;
        pulse_reset();
        s0 = step_seen;
        enc_a = 1'b1;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #2;
            if (count !== 16'h0000) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 32'd7);
        repeat (20) @(negedge clk);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 20);
        hold(1'b0, 1'b0, 20);
        check("up_count", count, 32'd4);
        check("up_dir", dir, 32'd1);
        check("up_steps", step_seen - s0, 32'd4);

        // Down through zero, then back up across the all-ones boundary.
        pulse_reset();
        s0 = step_seen;
        hold(1'b0, 1'b1, 20);
        hold(1'b1, 1'b1, 20);
        hold(1'b1, 1'b0, 20);
        check("down_count", count, 32'hFFFD);
        check("down_dir", dir, 32'd0);
        check("down_steps", step_seen - s0, 32'd3);
        hold(1'b1, 1'b1, 20);
        hold(1'b0, 1'b1, 20);
        check("allones", count, 32'hFFFF);
        hold(1'b0, 1'b0, 20);
        check("wrap_zero", count, 32'd0);

        // Glitch rejection: 3-cycle pulse dropped, 4-cycle pulse counted up then down.
        s0 = step_seen;
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b0, 20);
        check("glitch3_count", count, 32'd0);
        check("glitch3_steps", step_seen - s0, 32'd0);
        hold(1'b1, 1'b0, 4);
        hold(1'b0, 1'b0, 4);
        check("glitch4_up", count, 32'd1);
        hold(1'b0, 1'b0, 20);
        check("glitch4_back", count, 32'd0);
        check("glitch4_steps", step_seen - s0, 32'd2);

        // Illegal 00->11, err_clear, then err_clear coinciding with a new illegal edge.
        s0 = step_seen;
        hold(1'b1, 1'b1, 20);
        check("illegal_err", error, 32'd1);
        check("illegal_count", count, 32'd0);
        check("illegal_dir", dir, 32'd0);
        check("illegal_steps", step_seen - s0, 32'd0);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
        check("err_cleared", error, 32'd0);
        enc_a = 1'b0; enc_b = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("set_wins", error, 32'd1);
        repeat (10) @(negedge clk);

        // clear on the very cycle a step is decoded.
        hold(1'b1, 1'b0, 20);
        check("pre_clear", count, 32'd1);
        enc_a = 1'b1; enc_b = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #2;
        check("clear_step", step, 32'd1);
        check("clear_count", count, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        repeat (20) @(negedge clk);

        // Reset while an edge is still inside the filter.
        hold(1'b0, 1'b1, 20);
        check("pre_reset", count, 32'd1);
        enc_a = 1'b0; enc_b = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_count", count, 32'd0);
        check("rst_dir", dir, 32'd0);
        check("rst_error", error, 32'd0);
        s0 = step_seen;
        repeat (20) @(negedge clk);
        check("rst_pending_count", count, 32'd0);
        check("rst_pending_steps", step_seen - s0, 32'd0);

        // Randomized walk: mostly Gray steps, some illegal jumps and short glitches.
        rpos = 0;
        for (int seg = 0; seg < 300; seg++) begin
            rpos = (rpos + int'($urandom_range(0, 3))) % 4;
            enc_a = (rpos == 1) || (rpos == 2);
            enc_b = (rpos == 2) || (rpos == 3);
            hold_n = int'($urandom_range(1, 12));
            for (int c = 0; c < hold_n; c++) begin
                clear     = ($urandom_range(0, 29) == 0);
                err_clear = ($urandom_range(0, 14) == 0);
                reset     = ($urandom_range(0, 199) != 0);
                @(negedge clk);
            end
        end
        clear = 1'b0; err_clear = 1'b0; reset = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
